load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the main decoder.
- Consumes the decoder's 4-bit mem_w control field ({funct3, write_enable}) together with the ALU-computed address and the rs2 store data.
- Performs one outstanding load or store on a valid/ready data-memory bus, with byte-lane steering, sign/zero extension, misalignment checking and a bus timeout.
- Returns a one-cycle writeback response to the register-file write path.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting in BUS_RSP before the access is aborted with a timeout error. Legal range 1..65535.
- RESET_STATE, LSU_IDLE: initial FSM state, from the package enum.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- req_valid  in  1  execute stage presents a memory operation
- req_ready  out  1  LSU can accept a request
- mem_w  in  4  {funct3, we}; we=1 means store, we=0 means load
- addr  in  32  byte address from the ALU
- wdata  in  32  store data (rs2)
- rd  in  5  destination register for loads
- flush  in  1  kill the in-flight operation (branch/jump redirect)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts the request
- mem_addr  out  32  word-aligned bus address {addr[31:2], 2'b00}
- mem_we  out  1  bus write
- mem_wstrb  out  4  byte-lane strobes (0 for loads)
- mem_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  bus response or store acknowledge
- mem_rdata  in  32  bus read word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_wb_en  out  1  write rsp_data to rsp_rd (loads only, no error)
- rsp_rd  out  5  destination register
- rsp_data  out  32  extended load data
- rsp_err  out  2  lsu_err_e code

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FSM in RESET_STATE; every output 0, including req_ready while rst=1; timeout counter 0; kill flag 0.
- Handshake: req_ready=1 only in LSU_IDLE. A request is accepted on req_valid && req_ready, which captures mem_w, addr, wdata and rd. There is no response backpressure.
- Decode, loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Decode, stores: 000 SB, 001 SH, 010 SW.
- Illegal funct3 (any other value): ERR_ILLEGAL.
- Misalignment: a halfword with addr[0]=1, or a word with addr[1:0]!=0, gives ERR_MISALIGN.
- Error priority: ERR_ILLEGAL over ERR_MISALIGN. Either error goes IDLE→RESP with no bus transaction.
- Store steering:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 or 1100 by addr[1], wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
- Load extraction: select byte or halfword by addr[1:0] from mem_rdata. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: LSU_IDLE, LSU_BUS_REQ, LSU_BUS_RSP, LSU_RESP.
- Transitions:
  - IDLE→BUS_REQ on a legal accept.
  - BUS_REQ holds mem_req_valid and all mem_* outputs stable until mem_req_ready, then →BUS_RSP.
  - BUS_RSP→RESP on mem_rsp_valid, with load data registered.
  - BUS_RSP→RESP with ERR_TIMEOUT when the counter reaches TIMEOUT_CYCLES. The counter clears on BUS_RSP entry.
  - RESP drives rsp_valid for exactly one cycle, then →IDLE.
- Latency: minimum 3 cycles from accept to rsp_valid (accept N, bus handshake N+1, mem_rsp_valid N+2, rsp_valid N+3). Errors complete with rsp_valid at N+1.
- mem_rsp_valid outside BUS_RSP is ignored.
- Response fields: rsp_wb_en = load && rsp_err==ERR_NONE. rsp_data=0 on any error or store.
- Flush in BUS_REQ before the handshake: →IDLE immediately, no bus transaction, no rsp_valid.
- Flush in BUS_RSP: set the kill flag. Still wait for mem_rsp_valid or timeout, then go →IDLE without rsp_valid. A store already issued is not undone.
- Flush in RESP: rsp_valid is suppressed.
- Flush in IDLE with a simultaneous req_valid: the request is not accepted.
- rst mid-operation: immediate return to IDLE with outputs zeroed. A pending bus response arriving afterwards is ignored.

Decomposition:
- riscv_pkg gains:
  - lsu_state_e (4 states)
  - lsu_err_e: ERR_NONE=0, ERR_MISALIGN=1, ERR_ILLEGAL=2, ERR_TIMEOUT=3
  - funct3 constants for the load/store widths
  - lsu_rsp_t struct {valid, wb_en, rd, data, err}
- Sub-module lsu_align: purely combinational. Performs funct3 and address legality checking, strobe and lane replication for stores, and extract/extend for loads. It is unit-testable on its own.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, mem_req_ready=1, ack after 1 cycle → mem_wstrb=1111, mem_addr=0x100; rsp_valid at N+3, rsp_wb_en=0, rsp_err=0.
- SB addr 0x103, wdata 0x000000A5 → mem_wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- Loads of mem_rdata=0x80F0_7F81, rd=5:
  - LB addr 0x200 → rsp_data 0xFFFFFF81.
  - LBU addr 0x200 → rsp_data 0x00000081.
  - LH addr 0x202 → rsp_data 0xFFFF80F0.
  - Each with rsp_wb_en=1 and rsp_rd=5.
- Error paths:
  - LW addr 0x101 → no mem_req_valid; rsp_valid at N+1, rsp_err=1.
  - mem_w=0111 (illegal store funct3) → rsp_err=2.
- Timeout: TIMEOUT_CYCLES=4, bus never responds → rsp_err=3 after 4 cycles in BUS_RSP; req_ready back to 1 the next cycle.
- Flush and reset:
  - mem_req_ready held 0 for 3 cycles, flush in cycle 2 → mem_req_valid drops, no rsp_valid.
  - flush in BUS_RSP, then mem_rsp_valid → no rsp_valid, returns to IDLE.
  - rst asserted mid-BUS_RSP → all outputs 0 the next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store-unit types: FSM states, error codes, funct3 widths and response record.
package riscv_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE    = 2'd0,
        LSU_BUS_REQ = 2'd1,
        LSU_BUS_RSP = 2'd2,
        LSU_RESP    = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_ILLEGAL  = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } lsu_err_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] data;
        lsu_err_e    err;
    } lsu_rsp_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational access checker, store lane steering and load extract/extend.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_we,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output lsu_err_e    o_err,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the bus word
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Legality check: illegal encodings take priority over misalignment
    always_comb begin
        o_err = ERR_NONE;
        case (i_funct3)
            F3_B:    o_err = ERR_NONE;
            F3_H:    if (i_addr_lo[0]) o_err = ERR_MISALIGN;
            F3_W:    if (i_addr_lo != 2'b00) o_err = ERR_MISALIGN;
            F3_BU:   if (i_we) o_err = ERR_ILLEGAL;
            F3_HU: begin
                if (i_we)              o_err = ERR_ILLEGAL;
                else if (i_addr_lo[0]) o_err = ERR_MISALIGN;
            end
            default: o_err = ERR_ILLEGAL;
        endcase
    end

    // Store strobes and lane replication; strobes are zero for loads
    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
        if (!i_we) o_wstrb = '0;
    end

    // Load extension: signed for LB/LH, zero for LBU/LHU, whole word for LW
    always_comb begin
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'd0, w_half};
            default: o_rdata = i_rdata;
        endcase
        if (i_we) o_rdata = '0;
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the decoder/ALU and a valid/ready data bus.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter lsu_state_e  RESET_STATE    = LSU_IDLE
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic        rsp_wb_en,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err
);

    lsu_state_e  r_state, w_next;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    lsu_err_e    r_err;
    logic [31:0] r_rdata;
    logic [15:0] r_cnt;
    logic        r_kill;

    logic        w_idle;
    logic        w_accept;
    logic        w_timeout;
    logic [2:0]  w_f3;
    logic        w_we;
    logic [1:0]  w_lo;
    logic [31:0] w_wd;
    lsu_err_e    w_err;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata_lane;
    logic [31:0] w_rdata_ext;
    lsu_rsp_t    w_rsp;

    // One aligner serves both ends: live request fields in IDLE, captured fields afterwards
    assign w_idle    = (r_state == LSU_IDLE);
    assign w_f3      = w_idle ? mem_w[3:1] : r_funct3;
    assign w_we      = w_idle ? mem_w[0]   : r_we;
    assign w_lo      = w_idle ? addr[1:0]  : r_addr[1:0];
    assign w_wd      = w_idle ? wdata      : r_wdata;
    assign w_accept  = w_idle && req_valid && !flush && !rst;
    assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .i_funct3  (w_f3),
        .i_we      (w_we),
        .i_addr_lo (w_lo),
        .i_wdata   (w_wd),
        .i_rdata   (mem_rdata),
        .o_err     (w_err),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata_lane),
        .o_rdata   (w_rdata_ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= RESET_STATE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_IDLE:    if (w_accept) w_next = (w_err == ERR_NONE) ? LSU_BUS_REQ : LSU_RESP;
            LSU_BUS_REQ: begin
                if (flush)              w_next = LSU_IDLE;
                else if (mem_req_ready) w_next = LSU_BUS_RSP;
            end
            LSU_BUS_RSP: if (mem_rsp_valid || w_timeout) w_next = (r_kill || flush) ? LSU_IDLE : LSU_RESP;
            default:     w_next = LSU_IDLE;
        endcase
    end

    // Request capture, timeout counter, kill flag and load-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3 <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= '0;
            r_err    <= ERR_NONE;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_kill   <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: if (w_accept) begin
                    r_funct3 <= mem_w[3:1];
                    r_we     <= mem_w[0];
                    r_addr   <= addr;
                    r_wdata  <= wdata;
                    r_rd     <= rd;
                    r_err    <= w_err;
                    r_rdata  <= '0;
                    r_kill   <= 1'b0;
                end
                LSU_BUS_REQ: if (!flush && mem_req_ready) r_cnt <= '0;
                LSU_BUS_RSP: begin
                    if (flush) r_kill <= 1'b1;
                    if (mem_rsp_valid)  r_rdata <= w_rdata_ext;
                    else if (w_timeout) r_err   <= ERR_TIMEOUT;
                    else                r_cnt   <= r_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: bus fields only in BUS_REQ, response only in RESP, everything zero under reset
    always_comb begin
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wstrb     = '0;
        mem_wdata     = '0;
        w_rsp         = '0;
        if (!rst) begin
            case (r_state)
                LSU_IDLE: req_ready = 1'b1;
                LSU_BUS_REQ: begin
                    mem_req_valid = !flush;
                    mem_addr      = {r_addr[31:2], 2'b00};
                    mem_we        = r_we;
                    mem_wstrb     = w_wstrb;
                    mem_wdata     = w_wdata_lane;
                end
                LSU_RESP: if (!flush) begin
                    w_rsp.valid = 1'b1;
                    w_rsp.wb_en = !r_we && (r_err == ERR_NONE);
                    w_rsp.rd    = r_rd;
                    w_rsp.data  = r_rdata;
                    w_rsp.err   = r_err;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = w_rsp.valid;
    assign rsp_wb_en = w_rsp.wb_en;
    assign rsp_rd    = w_rsp.rd;
    assign rsp_data  = w_rsp.data;
    assign rsp_err   = w_rsp.err;

endmodule
